// File: rtl/wisc_pkg.sv
// Shared WISC execute-stage definitions: widths, opcodes, condition codes,
// controller state encoding and flag bit positions.
package wisc_pkg;

    localparam int unsigned DW  = 16;
    localparam int unsigned CW  = 3;
    localparam int unsigned OPW = 4;
    localparam int unsigned RDW = 4;
    localparam int unsigned FW  = 3;

    localparam logic [OPW-1:0] OP_ADD    = 4'h0;
    localparam logic [OPW-1:0] OP_SUB    = 4'h1;
    localparam logic [OPW-1:0] OP_XOR    = 4'h2;
    localparam logic [OPW-1:0] OP_RED    = 4'h3;
    localparam logic [OPW-1:0] OP_SLL    = 4'h4;
    localparam logic [OPW-1:0] OP_SRA    = 4'h5;
    localparam logic [OPW-1:0] OP_ROR    = 4'h6;
    localparam logic [OPW-1:0] OP_PADDSB = 4'h7;
    localparam logic [OPW-1:0] OP_LW     = 4'h8;
    localparam logic [OPW-1:0] OP_SW     = 4'h9;
    localparam logic [OPW-1:0] OP_LHB    = 4'hA;
    localparam logic [OPW-1:0] OP_LLB    = 4'hB;
    localparam logic [OPW-1:0] OP_B      = 4'hC;
    localparam logic [OPW-1:0] OP_BR     = 4'hD;
    localparam logic [OPW-1:0] OP_PCS    = 4'hE;
    localparam logic [OPW-1:0] OP_HLT    = 4'hF;

    localparam logic [CW-1:0] CC_NE = 3'b000;
    localparam logic [CW-1:0] CC_EQ = 3'b001;
    localparam logic [CW-1:0] CC_GT = 3'b010;
    localparam logic [CW-1:0] CC_LT = 3'b011;
    localparam logic [CW-1:0] CC_GE = 3'b100;
    localparam logic [CW-1:0] CC_LE = 3'b101;
    localparam logic [CW-1:0] CC_OV = 3'b110;
    localparam logic [CW-1:0] CC_UN = 3'b111;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        HALT = 2'd2
    } state_t;

    function automatic logic is_branch(input logic [OPW-1:0] op);
        return (op == OP_B) || (op == OP_BR);
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluator over the {Z,V,N} flag register.
module br_cond_eval
    import wisc_pkg::*;
(
    input  logic [CW-1:0] cond,
    input  logic [FW-1:0] flags,
    output logic          take
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLG_Z];
    assign w_v = flags[FLG_V];
    assign w_n = flags[FLG_N];

    always_comb begin
        take = 1'b0;
        case (cond)
            CC_NE:   take = !w_z;
            CC_EQ:   take = w_z;
            CC_GT:   take = !w_z && !w_n;
            CC_LT:   take = w_n;
            CC_GE:   take = w_z || (!w_z && !w_n);
            CC_LE:   take = w_n || w_z;
            CC_OV:   take = w_v;
            CC_UN:   take = 1'b1;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// WISC execute-stage controller: ID handshake, flag register, branch resolution,
// HLT handling and a registered result slot toward MEM.
// Optional performance counters are enabled with the macro ALU_EXEC_PERF_EN.
module alu_exec_ctrl
    import wisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  in_opcode,
    input  logic [CW-1:0]   in_cond,
    input  logic [RDW-1:0]  in_rd,
    output logic [OPW-1:0]  alu_op,
    input  logic [DW-1:0]   alu_res,
    input  logic            alu_ovf,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_res,
    output logic [RDW-1:0]  out_rd,
    output logic [OPW-1:0]  out_opcode,
    output logic            br_taken,
    output logic [FW-1:0]   flags,
    output logic            halted
`ifdef ALU_EXEC_PERF_EN
    ,
    output logic [15:0]     perf_retired,
    output logic [15:0]     perf_stall,
    output logic [15:0]     perf_taken
`endif
);

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_out_valid;
    logic [DW-1:0]   r_out_res;
    logic [RDW-1:0]  r_out_rd;
    logic [OPW-1:0]  r_out_opcode;
    logic            r_br_taken;
    logic [FW-1:0]   r_flags;
    logic            r_halted;
    logic            w_accept;
    logic            w_accept_hlt;
    logic            w_take;
    logic            w_res_zero;

    assign alu_op       = in_opcode;
    assign in_ready     = (r_state != HALT) && (!r_out_valid || out_ready);
    assign w_accept     = in_valid && in_ready;
    assign w_accept_hlt = w_accept && (in_opcode == OP_HLT);
    assign w_res_zero   = (alu_res == '0);

    assign out_valid  = r_out_valid;
    assign out_res    = r_out_res;
    assign out_rd     = r_out_rd;
    assign out_opcode = r_out_opcode;
    assign br_taken   = r_br_taken;
    assign flags      = r_flags;
    assign halted     = r_halted;

    br_cond_eval u_br_cond_eval (
        .cond  (in_cond),
        .flags (r_flags),
        .take  (w_take)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    // HOLD tracks a result stalled by MEM; HALT is sticky until reset
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN: begin
                if (w_accept_hlt)                     w_state_nxt = HALT;
                else if (r_out_valid && !out_ready)   w_state_nxt = HOLD;
            end
            HOLD: begin
                if (w_accept_hlt)                     w_state_nxt = HALT;
                else if (out_ready)                   w_state_nxt = RUN;
            end
            HALT:                                     w_state_nxt = HALT;
            default:                                  w_state_nxt = RUN;
        endcase
    end

    // Result slot: overwritten on accept, drained when MEM takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_res    <= '0;
            r_out_rd     <= '0;
            r_out_opcode <= '0;
            r_br_taken   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_res    <= alu_res;
            r_out_rd     <= in_rd;
            r_out_opcode <= in_opcode;
            r_br_taken   <= is_branch(in_opcode) && w_take;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flags <= '0;
        end else if (w_accept) begin
            case (in_opcode)
                OP_ADD, OP_SUB:                 r_flags <= {w_res_zero, alu_ovf, alu_res[DW-1]};
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: r_flags[FLG_Z] <= w_res_zero;
                default:                        r_flags <= r_flags;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                r_halted <= 1'b0;
        else if ((r_state == HALT) && r_out_valid && out_ready) r_halted <= 1'b1;
    end

`ifdef ALU_EXEC_PERF_EN
    logic [15:0] r_perf_retired;
    logic [15:0] r_perf_stall;
    logic [15:0] r_perf_taken;
    logic        w_retire;
    logic        w_stall;

    assign w_retire     = r_out_valid && out_ready;
    assign w_stall      = in_valid && !in_ready && (r_state != HALT);
    assign perf_retired = r_perf_retired;
    assign perf_stall   = r_perf_stall;
    assign perf_taken   = r_perf_taken;

    // Saturating event counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
            r_perf_taken   <= '0;
        end else begin
            if (w_retire && (r_perf_retired != 16'hFFFF))
                r_perf_retired <= r_perf_retired + 16'd1;
            if (w_stall && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
            if (w_retire && r_br_taken && (r_perf_taken != 16'hFFFF))
                r_perf_taken <= r_perf_taken + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl: behavioural model plus directed vectors.
module tb_alu_exec_ctrl;
    import wisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_opcode = 4'h0;
    logic [2:0]  in_cond = 3'b000;
    logic [3:0]  in_rd = 4'h0;
    logic [3:0]  alu_op;
    logic [15:0] alu_res = 16'h0000;
    logic        alu_ovf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_res;
    logic [3:0]  out_rd;
    logic [3:0]  out_opcode;
    logic        br_taken;
    logic [2:0]  flags;
    logic        halted;
`ifdef ALU_EXEC_PERF_EN
    logic [15:0] perf_retired;
    logic [15:0] perf_stall;
    logic [15:0] perf_taken;
`endif

    always #5 clk = ~clk;

    alu_exec_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_cond    (in_cond),
        .in_rd      (in_rd),
        .alu_op     (alu_op),
        .alu_res    (alu_res),
        .alu_ovf    (alu_ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_rd     (out_rd),
        .out_opcode (out_opcode),
        .br_taken   (br_taken),
        .flags      (flags),
        .halted     (halted)
`ifdef ALU_EXEC_PERF_EN
        ,
        .perf_retired (perf_retired),
        .perf_stall   (perf_stall),
        .perf_taken   (perf_taken)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one result slot, a flag triple, and a stopped/halted pair
    logic        m_valid;
    logic [15:0] m_res;
    logic [3:0]  m_rd;
    logic [3:0]  m_op;
    logic        m_br;
    logic [2:0]  m_flags;
    logic        m_stopped;
    logic        m_halted;

    function automatic logic cond_true(input logic [2:0] cc, input logic [2:0] f);
        logic z, v, n;
        z = f[2]; v = f[1]; n = f[0];
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [2:0] next_flags(input logic [3:0] op, input logic [15:0] res,
                                              input logic ovf, input logic [2:0] f);
        logic z;
        z = (res == 16'h0000);
        if (op == 4'h0 || op == 4'h1) return {z, ovf, res[15]};
        if (op == 4'h2 || op == 4'h4 || op == 4'h5 || op == 4'h6) return {z, f[1:0]};
        return f;
    endfunction

    function automatic logic model_ready();
        return !m_stopped && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 0; m_res = 0; m_rd = 0; m_op = 0; m_br = 0;
            m_flags = 0; m_stopped = 0; m_halted = 0;
        end else if (in_valid && model_ready()) begin
            m_br    = (in_opcode == 4'hC || in_opcode == 4'hD) ? cond_true(in_cond, m_flags) : 1'b0;
            m_flags = next_flags(in_opcode, alu_res, alu_ovf, m_flags);
            m_valid = 1; m_res = alu_res; m_rd = in_rd; m_op = in_opcode;
            if (in_opcode == 4'hF) m_stopped = 1;
        end else if (out_ready) begin
            if (m_valid && m_stopped) m_halted = 1;
            m_valid = 0;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
            chk("cyc_flags",     32'(flags),     32'(m_flags));
            chk("cyc_halted",    32'(halted),    32'(m_halted));
            chk("cyc_in_ready",  32'(in_ready),  32'(model_ready()));
            chk("cyc_alu_op",    32'(alu_op),    32'(in_opcode));
            if (m_valid) begin
                chk("cyc_out_res",    32'(out_res),    32'(m_res));
                chk("cyc_out_rd",     32'(out_rd),     32'(m_rd));
                chk("cyc_out_opcode", 32'(out_opcode), 32'(m_op));
                chk("cyc_br_taken",   32'(br_taken),   32'(m_br));
            end
        end
    end

    task automatic set(input logic v, input logic [3:0] op, input logic [2:0] cc, input logic [3:0] rd,
                       input logic [15:0] res, input logic ovf, input logic ordy);
        in_valid = v; in_opcode = op; in_cond = cc; in_rd = rd;
        alu_res = res; alu_ovf = ovf; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #20 rst = 1'b0;
        tick();
        run_cmp = 1'b1;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_flags",     32'(flags),     32'd0);
        chk("rst_halted",    32'(halted),    32'd0);
        chk("rst_out_res",   32'(out_res),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);

        set(1, 4'h0, 3'd0, 4'd1, 16'h0000, 0, 1); tick();
        chk("add0_valid", 32'(out_valid), 32'd1);
        chk("add0_res",   32'(out_res),   32'h0);
        chk("add0_flags", 32'(flags),     32'b100);

        set(1, 4'h1, 3'd0, 4'd2, 16'h8000, 1, 1); tick();
        chk("sub_flags", 32'(flags),   32'b011);
        chk("sub_res",   32'(out_res), 32'h8000);
        chk("sub_rd",    32'(out_rd),  32'd2);
        set(1, 4'h2, 3'd0, 4'd3, 16'h0001, 0, 1); tick();
        chk("xor_flags", 32'(flags), 32'b011);

        set(1, 4'h0, 3'd0, 4'd4, 16'h0000, 0, 1); tick();
        set(1, 4'hC, 3'd1, 4'd0, 16'h0042, 0, 1); tick();
        chk("b_eq_taken",  32'(br_taken),   32'd1);
        chk("b_eq_opcode", 32'(out_opcode), 32'hC);
        chk("b_eq_flags",  32'(flags),      32'b100);
        set(1, 4'h0, 3'd0, 4'd4, 16'h0000, 0, 1); tick();
        set(1, 4'hC, 3'd0, 4'd0, 16'h0042, 0, 1); tick();
        chk("b_ne_taken", 32'(br_taken), 32'd0);
        set(1, 4'h1, 3'd0, 4'd5, 16'h0005, 0, 1); tick();
        set(1, 4'hD, 3'd2, 4'd0, 16'h0100, 0, 1); tick();
        chk("br_gt_taken", 32'(br_taken), 32'd1);
        set(1, 4'hD, 3'd3, 4'd0, 16'h0100, 0, 1); tick();
        chk("br_lt_taken", 32'(br_taken), 32'd0);
        set(1, 4'h8, 3'd7, 4'd9, 16'h0000, 0, 1); tick();
        chk("lw_no_br",    32'(br_taken), 32'd0);
        chk("lw_flags",    32'(flags),    32'b000);

        set(1, 4'h2, 3'd0, 4'd5, 16'h1234, 0, 1); tick();
        chk("pre_stall_res", 32'(out_res), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            set(1, 4'h1, 3'd0, 4'd6, 16'h8000, 1, 0);
            #1 chk("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
            chk("stall_res",   32'(out_res),   32'h1234);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        set(1, 4'h1, 3'd0, 4'd6, 16'h8000, 1, 1);
        #1 chk("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("release_res",   32'(out_res), 32'h8000);
        chk("release_rd",    32'(out_rd),  32'd6);
        chk("release_flags", 32'(flags),   32'b011);

        set(1, 4'h0, 3'd0, 4'd7, 16'h0010, 0, 0); tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_flags",     32'(flags),     32'd0);
        chk("arst_in_ready",  32'(in_ready),  32'd1);
        #3 rst = 1'b0;
        set(0, 4'h0, 3'd0, 4'd0, 16'h0000, 0, 1); tick();

        set(1, 4'h0, 3'd0, 4'd1, 16'h8000, 1, 1); tick();
        chk("pre_hlt_flags", 32'(flags), 32'b011);
        set(1, 4'hF, 3'd0, 4'd0, 16'h0000, 0, 1); tick();
        chk("hlt_opcode", 32'(out_opcode), 32'hF);
        chk("hlt_valid",  32'(out_valid),  32'd1);
        chk("hlt_halted", 32'(halted),     32'd0);
        set(1, 4'h0, 3'd0, 4'd2, 16'h0000, 0, 1);
        #1 chk("hlt_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("halted_set",   32'(halted),    32'd1);
        chk("halted_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 10; i++) begin
            set(1, 4'h0, 3'd0, 4'd3, 16'h0000, 0, 1);
            #1 chk("halt_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        chk("halt_flags",  32'(flags),  32'b011);
        chk("halt_sticky", 32'(halted), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
